// File: rtl/sram_pkg.sv
// sram_pkg: state encoding and default parameter constants shared by the SRAM block.
`default_nettype none

package sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sp_sram_core.sv
// sp_sram_core: single-port storage array with byte-enable write and registered read.
`default_nettype none

module sp_sram_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  we,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic                  rzero,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; they are defined by the initialisation sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // rzero marks an out-of-range address, so mem is only indexed when in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= re;
      if (re) begin
        dout <= rzero ? '0 : mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_sp_sram.sv
// param_sp_sram: parameterised single-port SRAM with init sweep, clear, and range check.
`default_nettype none

module param_sp_sram
  import sram_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = 2**ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  w_r,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  clr,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy
);

  localparam int                NB      = bytes_of(DATA_W);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic              in_range;
  logic              accept;
  logic [ADDR_W-1:0] core_addr;
  logic              core_we;
  logic [DATA_W-1:0] core_wdata;
  logic [NB-1:0]     core_be;
  logic              core_re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter returns to 0 on leaving INIT so a later clr restarts cleanly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        if (cnt == LAST) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == ST_INIT);
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign accept   = (state == ST_READY) && en && !clr;

  // During INIT the sweep owns the array port; user requests are ignored.
  assign core_addr  = busy ? cnt : addr;
  assign core_we    = busy || (accept && w_r && in_range);
  assign core_wdata = busy ? INIT_VAL : din;
  assign core_be    = busy ? {NB{1'b1}} : be;
  assign core_re    = accept && !w_r;

  sp_sram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .addr       (core_addr),
    .we         (core_we),
    .wdata      (core_wdata),
    .be         (core_be),
    .re         (core_re),
    .rzero      (!in_range),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_param_sp_sram.sv
// tb_param_sp_sram: directed and random checks of two param_sp_sram instances against a word-level model.
`default_nettype none

module tb_param_sp_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        w_r = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] din = '0;
  logic [1:0]  be = '0;
  logic        clr = 1'b0;

  logic [15:0] dout_w [2];
  logic        dv_w   [2];
  logic        busy_w [2];

  always #5 clk = ~clk;

  param_sp_sram #(.DATA_W(16), .ADDR_W(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .w_r(w_r), .addr(addr), .din(din), .be(be), .clr(clr),
    .dout(dout_w[0]), .dout_valid(dv_w[0]), .busy(busy_w[0])
  );

  param_sp_sram #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .INIT_VAL(16'h00A5)) dut1 (
    .clk(clk), .rst(rst), .en(en), .w_r(w_r), .addr(addr), .din(din), .be(be), .clr(clr),
    .dout(dout_w[1]), .dout_valid(dv_w[1]), .busy(busy_w[1])
  );

  // Reference model: word array plus remaining-init-cycles per instance.
  int          dep  [2] = '{16, 12};
  logic [15:0] ival [2] = '{16'h0000, 16'h00A5};
  logic [15:0] mmem [2][16];
  int          left [2];
  logic [15:0] ed   [2];
  logic        ev   [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        if (left[i] > 0) begin
          mmem[i][dep[i] - left[i]] = ival[i];
          left[i]--;
          ev[i] = 1'b0;
        end else if (clr) begin
          left[i] = dep[i];
          ev[i]   = 1'b0;
        end else if (en && w_r) begin
          ev[i] = 1'b0;
          if (int'(addr) < dep[i]) begin
            for (int b = 0; b < 2; b++)
              if (be[b]) mmem[i][addr][8*b +: 8] = din[8*b +: 8];
          end
        end else if (en) begin
          ev[i] = 1'b1;
          ed[i] = (int'(addr) < dep[i]) ? mmem[i][addr] : 16'h0000;
        end else begin
          ev[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s busy%0d", where, i), {31'd0, busy_w[i]}, {31'd0, left[i] > 0});
      check_eq($sformatf("%s valid%0d", where, i), {31'd0, dv_w[i]}, {31'd0, ev[i]});
      check_eq($sformatf("%s dout%0d", where, i), {16'd0, dout_w[i]}, {16'd0, ed[i]});
    end
  endtask

  task automatic cycle(input string where);
    model_step();
    @(posedge clk);
    #1;
    compare_all(where);
  endtask

  task automatic idle(input int n);
    en  = 1'b0;
    clr = 1'b0;
    for (int k = 0; k < n; k++) cycle("idle");
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    en = 1'b1; w_r = 1'b1; addr = a; din = d; be = b;
    cycle("wr");
    en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    en = 1'b1; w_r = 1'b0; addr = a;
    cycle("rd");
    en = 1'b0;
  endtask

  // Asserts rst away from a clock edge and checks the outputs react without a clock.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      left[i] = dep[i];
      ev[i]   = 1'b0;
      ed[i]   = 16'h0000;
    end
    compare_all("rst_async");
    cycle("rst_hold");
    cycle("rst_hold");
    #2;
    rst = 1'b0;
  endtask

  task automatic measure_init();
    int hi [2];
    #1;
    for (int i = 0; i < 2; i++) hi[i] = busy_w[i] ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      cycle("init");
      for (int i = 0; i < 2; i++) if (busy_w[i]) hi[i]++;
    end
    check_eq("busy_len0", hi[0], 16);
    check_eq("busy_len1", hi[1], 12);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      left[i] = dep[i];
      ev[i]   = 1'b0;
      ed[i]   = 16'h0000;
      for (int j = 0; j < 16; j++) mmem[i][j] = 16'h0000;
    end

    #3;
    apply_reset();
    measure_init();

    rd(4'd5);
    idle(1);

    wr(4'd11, 16'hA5C3, 2'b11);
    rd(4'd11);
    idle(1);

    wr(4'd3, 16'hFFFF, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd(4'd3);
    wr(4'd3, 16'h7700, 2'b00);
    rd(4'd3);
    idle(1);

    wr(4'd13, 16'h5555, 2'b11);
    rd(4'd13);
    rd(4'd0);
    idle(2);

    // clr wins over a simultaneous write request.
    en = 1'b1; w_r = 1'b1; addr = 4'd0; din = 16'h0BAD; be = 2'b11; clr = 1'b1;
    cycle("clr");
    en = 1'b0; clr = 1'b0;
    idle(17);
    for (int a = 0; a < 16; a++) begin
      en = 1'b1; w_r = 1'b0; addr = 4'(a);
      cycle("rd_all");
    end
    idle(2);

    for (int k = 0; k < 400; k++) begin
      en   = 1'($urandom_range(0, 1));
      w_r  = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      din  = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      clr  = ($urandom_range(0, 39) == 0);
      cycle("rand");
    end
    idle(20);

    wr(4'd9, 16'hBEEF, 2'b11);
    clr = 1'b1;
    cycle("clr2");
    clr = 1'b0;
    idle(7);
    apply_reset();
    measure_init();
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/param_sp_sram.md
PARAM_SP_SRAM -- requirements
Module: param_sp_sram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 4, address width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, number of words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter INIT_VAL, default 0, word written to every location during initialisation.
REQ-005 SHALL have one clock and an asynchronous active-high reset; all other ports SHALL be synchronous to clk.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 en  input  1  request strobe; one access per cycle when high.
REQ-009 w_r  input  1  1 = write, 0 = read.
REQ-010 addr  input  ADDR_W  word address.
REQ-011 din  input  DATA_W  write data.
REQ-012 be  input  DATA_W/8  byte enables for writes; bit i covers din[8i+7:8i].
REQ-013 clr  input  1  request re-initialisation of the whole array.
REQ-014 dout  output  DATA_W  registered read data.
REQ-015 dout_valid  output  1  one-cycle pulse, dout carries a new read result.
REQ-016 busy  output  1  high while initialisation runs; requests are ignored.

Function
REQ-017 SHALL implement FSM states INIT and READY; INIT entered on reset release and on clr sampled high in READY.
REQ-018 In INIT a counter from 0 to DEPTH-1 SHALL write INIT_VAL to one address per cycle; after writing DEPTH-1 the FSM SHALL go to READY (INIT lasts exactly DEPTH cycles).
REQ-019 busy SHALL be high exactly in INIT; en, clr SHALL be ignored while busy.
REQ-020 Write (en=1, w_r=1, READY) SHALL update only the bytes with be[i]=1 at the rising edge; be=0 SHALL leave memory unchanged.
REQ-021 Read (en=1, w_r=0, READY) SHALL present mem[addr] on dout with dout_valid=1 in the cycle after acceptance (latency 1).
REQ-022 dout SHALL hold its last value when no read completes; dout_valid SHALL be 0 then.
REQ-023 Back-to-back reads SHALL each produce one valid pulse; throughput one access per cycle.
REQ-024 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-025 addr >= DEPTH: writes SHALL be discarded; reads SHALL return 0 with dout_valid=1.
REQ-026 clr and en high together in READY: clr SHALL win, the access SHALL be dropped, no dout_valid.
REQ-027 A read accepted in the cycle clr is sampled is not possible (REQ-026); no valid pulse SHALL appear during INIT.

Reset
REQ-028 rst high SHALL immediately force: state INIT, init counter 0, dout 0, dout_valid 0, busy 1.
REQ-029 rst mid-INIT or mid-access SHALL abort it; initialisation SHALL restart from address 0 after release.
REQ-030 Memory contents SHALL not be reset directly; they SHALL be defined only via the INIT sweep.

Structure
REQ-031 Shared package sram_pkg SHALL hold the FSM state encoding (INIT, READY) and default parameter constants.
REQ-032 The storage array with byte-enable write and registered read SHALL be sub-module sp_sram_core; param_sp_sram SHALL contain the FSM, counter, address check and port muxing.

Verification
REQ-033 Reset then idle: busy=1 for 16 cycles after rst release, then 0; read addr 5 -> dout=0x0000, dout_valid one cycle later.
REQ-034 Write addr 11 din=0xA5C3 be=11, next cycle read addr 11 -> dout=0xA5C3 one cycle after read.
REQ-035 Write addr 3 din=0xFFFF be=11, then addr 3 din=0x1234 be=01 -> read addr 3 returns 0xFF34.
REQ-036 DEPTH=12: write addr 13 din=0x5555 then read addr 13 -> dout=0x0000, dout_valid=1; read addr 0 unchanged.
REQ-037 After writes, pulse clr with en=1 w_r=1 addr 0 din=0x0BAD -> busy 12/16 cycles, write dropped, all reads return INIT_VAL.
REQ-038 Assert rst at INIT counter 7 -> dout=0, dout_valid=0 immediately; after release busy lasts a full DEPTH cycles.
